// File: rtl/a2d_sched.sv
// Round-robin A2D conversion scheduler: one channel (batt, curr, brake, torque) per tick,
// each conversion a command transaction then a read transaction on the shared SPI master.
module a2d_sched #(
  parameter int FAST_SIM = 0,
  parameter int TMO_CYC  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        snd,
  output logic [15:0] cmd,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        cnv_cmplt,
  output logic        tmo_err
);

  localparam int TW = (FAST_SIM != 0) ? 9 : 14;
  localparam int CW = $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {IDLE, CMD, WAIT_C, GAP, RD, WAIT_R} state_t;

  state_t          state_q;
  logic [TW-1:0]   tick_cnt_q;
  logic [TW-1:0]   tick_cnt_d;
  logic            tick;
  logic            pend_q;
  logic [1:0]      ptr_q;
  logic [CW-1:0]   tmo_cnt_q;
  logic            tmo_hit;
  logic [2:0]      ch;
  logic            unused_rd;

  assign unused_rd  = ^rd_data[15:12];
  assign tick_cnt_d = tick_cnt_q + 1'b1;
  assign tick       = &tick_cnt_q;
  assign tmo_hit    = (tmo_cnt_q == CW'(TMO_CYC - 1));

  // Slot to A2D channel map; channel 2 is not sampled.
  always_comb begin
    ch = 3'd4;
    case (ptr_q)
      2'd0:    ch = 3'd0;
      2'd1:    ch = 3'd1;
      2'd2:    ch = 3'd3;
      default: ch = 3'd4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      ptr_q     <= 2'd0;
      tmo_cnt_q <= '0;
      snd       <= 1'b0;
      cmd       <= 16'h0000;
      batt      <= 12'h000;
      curr      <= 12'h000;
      brake     <= 12'h000;
      torque    <= 12'h000;
      cnv_cmplt <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      snd       <= 1'b0;
      cnv_cmplt <= 1'b0;
      // A tick while busy is remembered once; later ones collapse into it.
      if (tick && (state_q != IDLE)) pend_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (tick || pend_q) begin
            state_q <= CMD;
            snd     <= 1'b1;
            cmd     <= {2'b00, ch, 11'h000};
            pend_q  <= 1'b0;
          end
        end
        CMD: begin
          state_q   <= WAIT_C;
          tmo_cnt_q <= '0;
        end
        WAIT_C: begin
          if (done) begin
            state_q <= GAP;
          end else if (tmo_hit) begin
            tmo_err <= 1'b1;
            ptr_q   <= ptr_q + 2'd1;
            state_q <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        GAP: begin
          state_q <= RD;
          snd     <= 1'b1;
        end
        RD: begin
          state_q   <= WAIT_R;
          tmo_cnt_q <= '0;
        end
        WAIT_R: begin
          if (done) begin
            case (ptr_q)
              2'd0:    batt   <= rd_data[11:0];
              2'd1:    curr   <= rd_data[11:0];
              2'd2:    brake  <= rd_data[11:0];
              default: torque <= rd_data[11:0];
            endcase
            cnv_cmplt <= 1'b1;
            ptr_q     <= ptr_q + 2'd1;
            state_q   <= IDLE;
          end else if (tmo_hit) begin
            tmo_err <= 1'b1;
            ptr_q   <= ptr_q + 2'd1;
            state_q <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_sched.sv
// Directed bench for a2d_sched; a second instance with a long timeout exercises ticks during a stall.
module tb_a2d_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, done, done2;
  logic [15:0] rd_data, rd_data2;
  logic        snd, snd2, cnv_cmplt, cnv2, tmo_err, tmo2;
  logic [15:0] cmd, cmd2;
  logic [11:0] batt, curr, brake, torque, batt2, curr2, brake2, torque2;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  a2d_sched #(.FAST_SIM(1), .TMO_CYC(255)) u_dut (
    .clk(clk), .rst_n(rst_n), .done(done), .rd_data(rd_data), .snd(snd), .cmd(cmd),
    .batt(batt), .curr(curr), .brake(brake), .torque(torque),
    .cnv_cmplt(cnv_cmplt), .tmo_err(tmo_err));

  a2d_sched #(.FAST_SIM(1), .TMO_CYC(2000)) u_pend (
    .clk(clk), .rst_n(rst_n), .done(done2), .rd_data(rd_data2), .snd(snd2), .cmd(cmd2),
    .batt(batt2), .curr(curr2), .brake(brake2), .torque(torque2),
    .cnv_cmplt(cnv2), .tmo_err(tmo2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // n = negedges until snd seen, -1 if the bound expired.
  task automatic wait_snd(input bit sel, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if ((sel ? snd2 : snd) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse(input bit sel, input logic [15:0] d);
    if (sel) begin done2 = 1'b1; rd_data2 = d; end
    else     begin done  = 1'b1; rd_data  = d; end
    @(negedge clk);
    done = 1'b0; done2 = 1'b0; rd_data = 16'h0; rd_data2 = 16'h0;
  endtask

  task automatic convert(input string tag, input logic [15:0] ecmd, input logic [15:0] d);
    int n;
    wait_snd(0, 600, n);
    chk({tag, "_snd_seen"}, 32'(n > 0), 32'd1);
    chk({tag, "_cmd"}, 32'(cmd), 32'(ecmd));
    repeat (5) @(negedge clk);
    pulse(0, 16'h0000);
    wait_snd(0, 3, n);
    chk({tag, "_rd_snd_after_gap"}, 32'(n), 32'd1);
    chk({tag, "_rd_cmd"}, 32'(cmd), 32'(ecmd));
    repeat (5) @(negedge clk);
    pulse(0, d);
    chk({tag, "_cnv_pulse"}, 32'(cnv_cmplt), 32'd1);
    @(negedge clk);
    chk({tag, "_cnv_single"}, 32'(cnv_cmplt), 32'd0);
  endtask

  initial begin
    int n;
    int c0;
    bit cnv_seen;
    rst_n = 1'b0; done = 1'b0; done2 = 1'b0; rd_data = 16'h0; rd_data2 = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_snd", 32'(snd), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_batt", 32'(batt), 32'd0);
    chk("rst_curr", 32'(curr), 32'd0);
    chk("rst_brake", 32'(brake), 32'd0);
    chk("rst_torque", 32'(torque), 32'd0);
    chk("rst_cnv", 32'(cnv_cmplt), 32'd0);
    chk("rst_tmo", 32'(tmo_err), 32'd0);
    rst_n = 1'b1;

    // First conversion: snd right after the 9-bit counter wraps.
    wait_snd(0, 600, n);
    chk("first_snd_cycle", 32'(n), 32'd512);
    chk("first_cmd", 32'(cmd), 32'h0000);
    @(negedge clk);
    chk("snd_not_back_to_back", 32'(snd), 32'd0);
    repeat (18) @(negedge clk);
    pulse(0, 16'h0000);
    chk("gap_no_snd", 32'(snd), 32'd0);
    pulse(0, 16'hDEAD);
    chk("rd_snd_after_gap", 32'(snd), 32'd1);
    chk("rd_cmd_same", 32'(cmd), 32'h0000);
    chk("gap_done_no_cnv", 32'(cnv_cmplt), 32'd0);
    chk("gap_done_no_capture", 32'(batt), 32'd0);
    repeat (19) @(negedge clk);
    pulse(0, 16'h0ABC);
    chk("first_batt", 32'(batt), 32'hABC);
    chk("first_cnv", 32'(cnv_cmplt), 32'd1);
    @(negedge clk);
    chk("first_cnv_single", 32'(cnv_cmplt), 32'd0);
    pulse(0, 16'h0FFF);
    chk("idle_done_no_cnv", 32'(cnv_cmplt), 32'd0);
    chk("idle_done_no_capture", 32'(batt), 32'hABC);
    chk("idle_done_no_snd", 32'(snd), 32'd0);

    convert("curr", 16'h0800, 16'h7123);
    chk("curr_val", 32'(curr), 32'h123);
    convert("brake", 16'h1800, 16'h0456);
    chk("brake_val", 32'(brake), 32'h456);
    convert("torque", 16'h2000, 16'hF789);
    chk("torque_val", 32'(torque), 32'h789);
    convert("batt_wrap", 16'h0000, 16'h0321);
    chk("batt_wrap_val", 32'(batt), 32'h321);
    chk("curr_kept", 32'(curr), 32'h123);

    // Read done withheld: timeout after 255 cycles in WAIT_R.
    wait_snd(0, 600, n);
    chk("tmo_cmd", 32'(cmd), 32'h0800);
    repeat (5) @(negedge clk);
    pulse(0, 16'h0000);
    wait_snd(0, 3, n);
    chk("tmo_rd_snd", 32'(n), 32'd1);
    cnv_seen = 1'b0;
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (cnv_cmplt) cnv_seen = 1'b1;
      if (tmo_err) begin
        n = i;
        break;
      end
    end
    chk("tmo_cycles", 32'(n), 32'd256);
    chk("tmo_no_cnv", 32'(cnv_seen), 32'd0);
    chk("tmo_curr_kept", 32'(curr), 32'h123);
    convert("after_tmo", 16'h1800, 16'h0AAA);
    chk("after_tmo_brake", 32'(brake), 32'hAAA);
    chk("tmo_sticky", 32'(tmo_err), 32'd1);

    // Reset while waiting for the command done.
    wait_snd(0, 600, n);
    chk("pre_rst_cmd", 32'(cmd), 32'h2000);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_snd", 32'(snd), 32'd0);
    chk("mid_rst_cmd", 32'(cmd), 32'd0);
    chk("mid_rst_batt", 32'(batt), 32'd0);
    chk("mid_rst_curr", 32'(curr), 32'd0);
    chk("mid_rst_brake", 32'(brake), 32'd0);
    chk("mid_rst_tmo", 32'(tmo_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Both instances restart together; u_pend then stalls across two ticks.
    wait_snd(1, 600, n);
    c0 = cyc;
    chk("post_rst_snd_cycle", 32'(n), 32'd512);
    chk("post_rst_dut_snd", 32'(snd), 32'd1);
    chk("post_rst_dut_batt", 32'(cmd), 32'h0000);
    chk("pend_first_cmd", 32'(cmd2), 32'h0000);
    repeat (1100) @(negedge clk);
    pulse(1, 16'h0000);
    wait_snd(1, 3, n);
    chk("pend_rd_snd", 32'(n), 32'd1);
    repeat (3) @(negedge clk);
    pulse(1, 16'h0111);
    chk("pend_batt", 32'(batt2), 32'h111);
    chk("pend_cnv", 32'(cnv2), 32'd1);
    @(negedge clk);
    chk("pend_served_next_cycle", 32'(snd2), 32'd1);
    chk("pend_cmd", 32'(cmd2), 32'h0800);
    repeat (3) @(negedge clk);
    pulse(1, 16'h0000);
    wait_snd(1, 3, n);
    chk("pend2_rd_snd", 32'(n), 32'd1);
    repeat (3) @(negedge clk);
    pulse(1, 16'h0222);
    chk("pend_curr", 32'(curr2), 32'h222);
    wait_snd(1, 600, n);
    chk("extra_tick_dropped", 32'(cyc - c0), 32'd1536);
    chk("after_pend_cmd", 32'(cmd2), 32'h1800);
    chk("pend_no_tmo", 32'(tmo2), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
